// File: rtl/mm_refill_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-cache miss-refill controller.
package mm_refill_ctrl_pkg;

  localparam int WORD_W            = 32;
  localparam int LINE_W            = 64;
  localparam int BLOCK_OFFSET_BITS = 3;

  localparam logic [WORD_W-1:0] BLOCK_MASK =
    ~((WORD_W'(1) << BLOCK_OFFSET_BITS) - WORD_W'(1));
  localparam logic [WORD_W-1:0] WORD_BYTES = WORD_W'(4);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    FILL  = 3'd5,
    HOLD  = 3'd6
  } state_e;

  function automatic logic [WORD_W-1:0] block_base(input logic [WORD_W-1:0] addr);
    return addr & BLOCK_MASK;
  endfunction

endpackage

// File: rtl/mm_refill_ctrl.sv
// Miss-refill controller: two 32-bit reads from main memory assembled into one 64-bit line.
// Optional re-issue on memory silence is enabled by defining MM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a miss (HitWrite low), PC sampled here only
// REQ0  | read strobe for the word at offset 0
// WAIT0 | waiting for the first beat
// REQ1  | read strobe for the word at offset 4
// WAIT1 | waiting for the second beat
// FILL  | Access_MM pulse, line handed to the cache
// HOLD  | one cycle that ignores a stale HitWrite from the cache
module mm_refill_ctrl
  import mm_refill_ctrl_pkg::*;
#(
  parameter int CNT_W = 20
`ifdef MM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                HitWrite,
  input  logic [WORD_W-1:0]   PC,
  output logic                MM_REQ,
  output logic [WORD_W-1:0]   MM_ADDR,
  input  logic [WORD_W-1:0]   MM_RDATA,
  input  logic                MM_RVALID,
  output logic                Access_MM,
  output logic [LINE_W-1:0]   Data_MM,
  output logic                BUSY,
  output logic [CNT_W-1:0]    CNT_REFILL
`ifdef MM_TIMEOUT_EN
  , output logic [CNT_W-1:0]  CNT_TIMEOUT
`endif
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WORD_W-1:0]  r_base;
  logic [WORD_W-1:0]  w_line_base;
  logic               r_mm_req;
  logic [WORD_W-1:0]  r_mm_addr;
  logic               r_access;
  logic [LINE_W-1:0]  r_data;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt_refill;

`ifdef MM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0]    r_wait_cnt;
  logic [CNT_W-1:0]   r_cnt_timeout;
  logic               w_in_wait;
  logic               w_timeout;

  assign w_in_wait = (r_state == WAIT0) || (r_state == WAIT1);
  assign w_timeout = w_in_wait && !MM_RVALID && (r_wait_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Counter is zero whenever the FSM is outside a wait state, so entry starts from zero.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wait_cnt    <= '0;
      r_cnt_timeout <= '0;
    end else begin
      if (w_in_wait && !MM_RVALID && !w_timeout)
        r_wait_cnt <= r_wait_cnt + TO_W'(1);
      else
        r_wait_cnt <= '0;
      if (w_timeout)
        r_cnt_timeout <= r_cnt_timeout + CNT_W'(1);
    end
  end

  assign CNT_TIMEOUT = r_cnt_timeout;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && !HitWrite)
        r_base <= block_base(PC);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (!HitWrite) w_state_nxt = REQ0;
      REQ0:  w_state_nxt = WAIT0;
      WAIT0: begin
        if (MM_RVALID) w_state_nxt = REQ1;
`ifdef MM_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = REQ0;
`endif
      end
      REQ1:  w_state_nxt = WAIT1;
      WAIT1: begin
        if (MM_RVALID) w_state_nxt = FILL;
`ifdef MM_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = REQ1;
`endif
      end
      FILL:    w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Base comes straight from PC on the IDLE->REQ0 edge, before r_base has captured it.
  assign w_line_base = (r_state == IDLE) ? block_base(PC) : r_base;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mm_req     <= 1'b0;
      r_mm_addr    <= '0;
      r_access     <= 1'b0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_cnt_refill <= '0;
    end else begin
      r_mm_req <= (w_state_nxt == REQ0) || (w_state_nxt == REQ1);
      if (w_state_nxt == REQ0)
        r_mm_addr <= w_line_base;
      else if (w_state_nxt == REQ1)
        r_mm_addr <= w_line_base + WORD_BYTES;
      r_access <= (w_state_nxt == FILL);
      if (w_state_nxt == FILL)
        r_cnt_refill <= r_cnt_refill + CNT_W'(1);
      if (r_state == WAIT0 && MM_RVALID)
        r_data[LINE_W-1:WORD_W] <= MM_RDATA;
      if (r_state == WAIT1 && MM_RVALID)
        r_data[WORD_W-1:0] <= MM_RDATA;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign MM_REQ     = r_mm_req;
  assign MM_ADDR    = r_mm_addr;
  assign Access_MM  = r_access;
  assign Data_MM    = r_data;
  assign BUSY       = r_busy;
  assign CNT_REFILL = r_cnt_refill;

endmodule

// File: tb/tb_mm_refill_ctrl.sv
// Directed bench for mm_refill_ctrl; with MM_TIMEOUT_EN a second instance checks the re-issue path.
module tb_mm_refill_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        HitWrite;
  logic [31:0] PC;
  logic [31:0] MM_RDATA;
  logic        MM_RVALID;
  logic        MM_REQ;
  logic [31:0] MM_ADDR;
  logic        Access_MM;
  logic [63:0] Data_MM;
  logic        BUSY;
  logic [19:0] CNT_REFILL;

  int vectors = 0;
  int miscompares = 0;
  int acc_pulses = 0;

  always #5 CLK = ~CLK;

`ifdef MM_TIMEOUT_EN
  logic        to_MM_REQ;
  logic [31:0] to_MM_ADDR;
  logic        to_Access_MM;
  logic [63:0] to_Data_MM;
  logic        to_BUSY;
  logic [19:0] to_CNT_REFILL;
  logic [19:0] to_CNT_TIMEOUT;
  logic [19:0] CNT_TIMEOUT;

  mm_refill_ctrl #(.CNT_W(20), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HitWrite(HitWrite), .PC(PC),
    .MM_REQ(MM_REQ), .MM_ADDR(MM_ADDR), .MM_RDATA(MM_RDATA), .MM_RVALID(MM_RVALID),
    .Access_MM(Access_MM), .Data_MM(Data_MM), .BUSY(BUSY), .CNT_REFILL(CNT_REFILL),
    .CNT_TIMEOUT(CNT_TIMEOUT)
  );

  mm_refill_ctrl #(.CNT_W(20), .TIMEOUT_CYC(4)) dut_to (
    .CLK(CLK), .RESET_N(RESET_N), .HitWrite(HitWrite), .PC(PC),
    .MM_REQ(to_MM_REQ), .MM_ADDR(to_MM_ADDR), .MM_RDATA(MM_RDATA), .MM_RVALID(MM_RVALID),
    .Access_MM(to_Access_MM), .Data_MM(to_Data_MM), .BUSY(to_BUSY), .CNT_REFILL(to_CNT_REFILL),
    .CNT_TIMEOUT(to_CNT_TIMEOUT)
  );
`else
  mm_refill_ctrl #(.CNT_W(20)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .HitWrite(HitWrite), .PC(PC),
    .MM_REQ(MM_REQ), .MM_ADDR(MM_ADDR), .MM_RDATA(MM_RDATA), .MM_RVALID(MM_RVALID),
    .Access_MM(Access_MM), .Data_MM(Data_MM), .BUSY(BUSY), .CNT_REFILL(CNT_REFILL)
  );
`endif

  always @(posedge CLK) if (Access_MM === 1'b1) acc_pulses++;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset, then idle with hits
    RESET_N = 1'b0; HitWrite = 1'b1; PC = 32'h0; MM_RDATA = 32'h0; MM_RVALID = 1'b0;
    repeat (3) tick();
    check("rst_ctl",  {61'd0, MM_REQ, Access_MM, BUSY}, 64'd0);
    check("rst_addr", {32'd0, MM_ADDR}, 64'd0);
    check("rst_data", Data_MM, 64'd0);
    check("rst_cnt",  {44'd0, CNT_REFILL}, 64'd0);
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", {61'd0, MM_REQ, Access_MM, BUSY}, 64'd0);
    end

    // Single miss at 0x44, 1-cycle memory
    PC = 32'h0000_0044; HitWrite = 1'b0;
    tick();
    check("s_req0",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h40});
    check("s_busy",  {63'd0, BUSY}, 64'd1);
    tick();
    check("s_wait0", {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b0, 32'h40});
    MM_RVALID = 1'b1; MM_RDATA = 32'hAAAA_0001;
    tick();
    check("s_req1",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h44});
    check("s_hi",    Data_MM, 64'hAAAA0001_00000000);
    MM_RVALID = 1'b0;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'hBBBB_0002;
    tick();
    check("s_fill",  {63'd0, Access_MM}, 64'd1);
    check("s_line",  Data_MM, 64'hAAAA0001_BBBB0002);
    check("s_cnt",   {44'd0, CNT_REFILL}, 64'd1);
    MM_RVALID = 1'b0;
    tick();
    check("s_hold",  {62'd0, Access_MM, BUSY}, 64'b01);
    tick();
    check("s_idle",  {62'd0, MM_REQ, BUSY}, 64'd0);
    check("s_keep",  Data_MM, 64'hAAAA0001_BBBB0002);
    HitWrite = 1'b1;

    // Variable latency (7 cycles per beat) with a spurious beat during REQ1
    PC = 32'h0000_200C; HitWrite = 1'b0;
    tick();
    check("v_req0",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h2008});
    HitWrite = 1'b1;
    tick();
    repeat (6) tick();
    check("v_wait0", {61'd0, MM_REQ, Access_MM, BUSY}, 64'b001);
    MM_RVALID = 1'b1; MM_RDATA = 32'h1111_2222;
    tick();
    check("v_req1",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h200C});
    MM_RDATA = 32'hDEAD_BEEF;
    tick();
    check("v_spur",  Data_MM, 64'h11112222_BBBB0002);
    check("v_nofill", {63'd0, Access_MM}, 64'd0);
    MM_RVALID = 1'b0;
    repeat (6) tick();
    check("v_wait1", {61'd0, MM_REQ, Access_MM, BUSY}, 64'b001);
    MM_RVALID = 1'b1; MM_RDATA = 32'h3333_4444;
    tick();
    check("v_fill",  {63'd0, Access_MM}, 64'd1);
    check("v_line",  Data_MM, 64'h11112222_33334444);
    check("v_cnt",   {44'd0, CNT_REFILL}, 64'd2);
    MM_RVALID = 1'b0;
    tick();
    tick();
    check("v_idle",  {63'd0, BUSY}, 64'd0);

    // PC moves mid-refill, then a back-to-back miss at 0x100
    PC = 32'h0000_0044; HitWrite = 1'b0;
    tick();
    check("p_req0",  {32'd0, MM_ADDR}, 64'h40);
    PC = 32'h0000_0100;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h5555_0001;
    tick();
    check("p_req1",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h44});
    MM_RVALID = 1'b0;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h6666_0002;
    tick();
    check("p_line",  Data_MM, 64'h55550001_66660002);
    check("p_cnt",   {44'd0, CNT_REFILL}, 64'd3);
    MM_RVALID = 1'b0;
    tick();
    tick();
    check("p_idle",  {63'd0, BUSY}, 64'd0);
    tick();
    check("b_req0",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h100});
    HitWrite = 1'b1;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_0007;
    tick();
    check("b_req1",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'h104});
    MM_RVALID = 1'b0;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_0008;
    tick();
    check("b_line",  Data_MM, 64'h00000007_00000008);
    check("b_cnt",   {44'd0, CNT_REFILL}, 64'd4);
    MM_RVALID = 1'b0;
    tick();
    tick();

    // Reset during WAIT1 discards the partial line
    PC = 32'h0000_0080; HitWrite = 1'b0;
    tick();
    HitWrite = 1'b1;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_0009;
    tick();
    MM_RVALID = 1'b0;
    tick();
    check("r_wait1", {63'd0, BUSY}, 64'd1);
    RESET_N = 1'b0;
    #1;
    check("r_ctl",   {61'd0, MM_REQ, Access_MM, BUSY}, 64'd0);
    check("r_data",  Data_MM, 64'd0);
    check("r_cnt",   {44'd0, CNT_REFILL}, 64'd0);
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_00AA;
    tick();
    tick();
    check("r_hold",  {61'd0, MM_REQ, Access_MM, BUSY}, 64'd0);
    MM_RVALID = 1'b0;
    #2 RESET_N = 1'b1;
    PC = 32'h0000_00C4; HitWrite = 1'b0;
    tick();
    check("r_req0",  {31'd0, MM_REQ, MM_ADDR}, {31'd0, 1'b1, 32'hC0});
    HitWrite = 1'b1;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_000B;
    tick();
    check("r_req1",  {32'd0, MM_ADDR}, 64'hC4);
    MM_RVALID = 1'b0;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_000C;
    tick();
    check("r_fill",  {63'd0, Access_MM}, 64'd1);
    check("r_line",  Data_MM, 64'h0000000B_0000000C);
    check("r_cnt1",  {44'd0, CNT_REFILL}, 64'd1);
    MM_RVALID = 1'b0;
    tick();
    tick();
    check("acc_total", 64'(acc_pulses), 64'd5);

`ifdef MM_TIMEOUT_EN
    // Timeout instance: memory silent on the first request
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    PC = 32'h0000_0200; HitWrite = 1'b0;
    tick();
    check("t_req0",  {31'd0, to_MM_REQ, to_MM_ADDR}, {31'd0, 1'b1, 32'h200});
    HitWrite = 1'b1;
    tick();
    repeat (3) tick();
    check("t_wait",  {63'd0, to_MM_REQ}, 64'd0);
    tick();
    check("t_reiss", {31'd0, to_MM_REQ, to_MM_ADDR}, {31'd0, 1'b1, 32'h200});
    check("t_cnt",   {44'd0, to_CNT_TIMEOUT}, 64'd1);
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_0D01;
    tick();
    check("t_req1",  {32'd0, to_MM_ADDR}, 64'h204);
    MM_RVALID = 1'b0;
    tick();
    MM_RVALID = 1'b1; MM_RDATA = 32'h0000_0D02;
    tick();
    check("t_fill",  {63'd0, to_Access_MM}, 64'd1);
    check("t_line",  to_Data_MM, 64'h00000D01_00000D02);
    check("t_cnt2",  {44'd0, to_CNT_TIMEOUT}, 64'd1);
    MM_RVALID = 1'b0;
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
